// File: rtl/bin_bcd_secuencial.sv
// Sequential binary-to-BCD converter (double dabble, one operand bit per clock).
// Accepts an operand on inicio while listo, and returns packed BCD with a one-cycle valido pulse.
module bin_bcd_secuencial #(
  parameter int ANCHO_BIN = 13,
  parameter int DIGITOS   = 4,
  parameter int CON_SIGNO = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inicio,
  input  logic [ANCHO_BIN-1:0]   binario,
  output logic                   listo,
  output logic                   valido,
  output logic [4*DIGITOS-1:0]   bcd,
  output logic                   signo,
  output logic                   desborde
);

  localparam int AB = 4 * DIGITOS;
  localparam int CW = $clog2(ANCHO_BIN + 1);

  localparam logic [0:0] REPOSO   = 1'b0;
  localparam logic [0:0] DESPLAZA = 1'b1;

  localparam logic [ANCHO_BIN-1:0] BIN_UNO = ANCHO_BIN'(1);
  localparam logic [CW-1:0]        CNT_UNO = CW'(1);
  localparam logic [CW-1:0]        CNT_INI = CW'(ANCHO_BIN);

  logic [0:0]           estado_q, estado_d;
  logic [ANCHO_BIN-1:0] op_q, op_d;
  logic [AB-1:0]        acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic                 neg_q, neg_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [AB-1:0]        bcd_q, bcd_d;
  logic                 signo_q, signo_d;
  logic                 desborde_q, desborde_d;
  logic                 valido_q, valido_d;

  logic [AB-1:0]        acc_adj;
  logic                 neg_in;
  logic [ANCHO_BIN-1:0] mag_in;

  // Two's-complement negation kept at ANCHO_BIN bits, so the most negative input yields 2^(ANCHO_BIN-1).
  assign neg_in = (CON_SIGNO != 0) && binario[ANCHO_BIN-1];
  assign mag_in = neg_in ? (~binario + BIN_UNO) : binario;

  generate
    for (genvar gi = 0; gi < DIGITOS; gi++) begin : g_ajuste
      assign acc_adj[4*gi +: 4] = (acc_q[4*gi +: 4] >= 4'd5) ? (acc_q[4*gi +: 4] + 4'd3)
                                                             : acc_q[4*gi +: 4];
    end
  endgenerate

  always_comb begin
    estado_d   = estado_q;
    op_d       = op_q;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    neg_d      = neg_q;
    cnt_d      = cnt_q;
    bcd_d      = bcd_q;
    signo_d    = signo_q;
    desborde_d = desborde_q;
    valido_d   = 1'b0;
    case (estado_q)
      REPOSO: begin
        if (inicio) begin
          op_d     = mag_in;
          neg_d    = neg_in;
          acc_d    = '0;
          ovf_d    = 1'b0;
          cnt_d    = CNT_INI;
          estado_d = DESPLAZA;
        end
      end
      default: begin
        // The bit leaving the top digit means the magnitude no longer fits.
        {acc_d, op_d} = {acc_adj[AB-2:0], op_q, 1'b0};
        ovf_d         = ovf_q | acc_adj[AB-1];
        cnt_d         = cnt_q - CNT_UNO;
        if (cnt_q == CNT_UNO) begin
          bcd_d      = acc_d;
          signo_d    = neg_q;
          desborde_d = ovf_d;
          valido_d   = 1'b1;
          estado_d   = REPOSO;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q   <= REPOSO;
      op_q       <= '0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      neg_q      <= 1'b0;
      cnt_q      <= '0;
      bcd_q      <= '0;
      signo_q    <= 1'b0;
      desborde_q <= 1'b0;
      valido_q   <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      op_q       <= op_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      neg_q      <= neg_d;
      cnt_q      <= cnt_d;
      bcd_q      <= bcd_d;
      signo_q    <= signo_d;
      desborde_q <= desborde_d;
      valido_q   <= valido_d;
    end
  end

  assign listo    = (estado_q == REPOSO);
  assign valido   = valido_q;
  assign bcd      = bcd_q;
  assign signo    = signo_q;
  assign desborde = desborde_q;

endmodule

// File: doc/bin_bcd_secuencial.md
# bin_bcd_secuencial

Multi-cycle, parametrised binary-to-BCD converter (double dabble, one bit per clock). It takes a binary operand on a start strobe and returns a packed BCD result with a one-cycle valid pulse, an overflow flag and an optional sign output. It sits between the adder datapath and the 7-segment display driver. It replaces the single-cycle combinational converter wherever operand width or digit count makes an unrolled loop too costly.

## Interface
- ANCHO_BIN, 13: width of the binary operand (≥2).
- DIGITOS, 4: number of BCD digits produced (≥1); `bcd` is 4·DIGITOS bits wide.
- CON_SIGNO, 0: 0 = operand is unsigned; 1 = operand is two's complement, and the magnitude is converted.
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- inicio  in  1  start strobe; sampled only while `listo`=1.
- binario  in  ANCHO_BIN  operand; sampled in the same cycle `inicio` is accepted.
- listo  out  1  converter idle, able to accept `inicio`.
- valido  out  1  one-cycle pulse; `bcd`/`signo`/`desborde` updated in this cycle.
- bcd  out  4·DIGITOS  packed BCD result; digit 0 in bits [3:0]; held between conversions.
- signo  out  1  1 = result is negative (always 0 when CON_SIGNO=0).
- desborde  out  1  1 = the magnitude exceeds 10^DIGITOS−1.

## Operation
- FSM states: REPOSO and DESPLAZA.
- REPOSO: `listo`=1.
  - On `inicio`=1, latch the magnitude of `binario` into the shift register.
  - With CON_SIGNO=1 and the MSB set, the magnitude is the two's-complement negation, computed as an ANCHO_BIN-bit unsigned value. The most negative input therefore converts to 2^(ANCHO_BIN−1).
  - Latch the sign, clear the BCD accumulator and the overflow accumulator, load the bit counter with ANCHO_BIN, and go to DESPLAZA.
- DESPLAZA: `listo`=0; `inicio` is ignored. Each cycle performs these steps in order:
  - every digit ≥5 gets +3;
  - shift {accumulator, operand} left by one, with the operand MSB entering digit 0 bit 0;
  - the bit leaving the top digit is ORed into the overflow accumulator;
  - decrement the counter.
- Counter reaching 0 on a shift:
  - the same edge registers the accumulator into `bcd`, the sign into `signo` and the overflow into `desborde`;
  - `valido` goes to 1 for one cycle;
  - the FSM returns to REPOSO.
- Overflow result: `bcd` holds the magnitude mod 10^DIGITOS and `desborde`=1.
- Zero result: `signo`=0, even if a negative zero cannot occur.
- `bcd` digits are always 0–9. No digit ever holds A–F at an output.

## Timing
- Reset values: `listo`=1, `valido`=0, `bcd`=0, `signo`=0, `desborde`=0, FSM=REPOSO, counter=0.
- `rst` has priority over `inicio`.
- Reset during DESPLAZA aborts the conversion. No `valido` is produced, and the outputs return to their reset values.
- Latency: `inicio` accepted at edge k. Shifts occur at edges k+1 … k+ANCHO_BIN, and `valido`=1 in the cycle after edge k+ANCHO_BIN.
- `listo` is 0 from edge k+1 through edge k+ANCHO_BIN. It is 1 again in the `valido` cycle.
- Back-to-back: `inicio` may be asserted in the `valido` cycle. The new operand is accepted there, giving one result every ANCHO_BIN+1 cycles.
- `binario` need not be held after the accept cycle.
- `bcd`, `signo` and `desborde` change only on a `valido` edge or on reset.

## Test plan
- Reset: assert `rst` 2 cycles during a conversion. Required: `listo`=1, `bcd`=0, `valido`=0, `desborde`=0, and no later `valido` pulse.
- Defaults, `binario`=8191 with one `inicio` pulse. Required: `valido` exactly 13 cycles after accept, `bcd`=16'h8191, `desborde`=0, and `listo` low for 13 cycles.
- Defaults, `binario`=0, then 1, then 4999, with `inicio` held high continuously. Required: `bcd`=16'h0000, 16'h0001, 16'h4999 on three `valido` pulses spaced 14 cycles apart.
- DIGITOS=3, `binario`=1234. Required: `bcd`=12'h234, `desborde`=1. Next conversion of 999 must give 12'h999, `desborde`=0 (overflow is not sticky across conversions).
- CON_SIGNO=1, ANCHO_BIN=8, DIGITOS=3. Inputs 8'hFF, 8'h80, 8'h7F. Required: (`signo`,`bcd`) = (1,12'h001), (1,12'h128), (0,12'h127).
- `inicio` pulsed mid-conversion with a different operand. Required: it is ignored, and the result matches the first operand.
